// File: rtl/debug_dump_serializer.sv
`default_nettype none
// ============================================================================
// Module   : debug_dump_serializer
// Function : snapshots a wide debug bus and streams it as HEADER, data, XOR CHK.
// Revision : 1.0 - initial release
// ============================================================================
module debug_dump_serializer #(
    parameter int         DATA_W    = 2558,
    parameter logic [7:0] HEADER    = 8'hA5,
    parameter bit         MSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] i_data_from_pipe,
    input  logic              is_start,
    input  logic              i_tx_done,
    output logic [7:0]        o_tx_byte,
    output logic              os_tx_start,
    output logic              o_busy,
    output logic              os_done
);

    localparam int c_nbytes = (DATA_W + 7) / 8;
    localparam int c_pad_w  = c_nbytes * 8;
    localparam int c_cnt_w  = $clog2(c_nbytes + 2);
    localparam int c_idx_w  = (c_nbytes > 1) ? $clog2(c_nbytes) : 1;

    // Item numbering: 0 = HEADER, 1..c_nbytes = data, c_nbytes+1 = CHK.
    localparam logic [c_cnt_w-1:0] c_last_data = c_cnt_w'(c_nbytes);
    localparam logic [c_cnt_w-1:0] c_last_item = c_cnt_w'(c_nbytes + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                      r_state;
    state_t                      w_next_state;
    logic [c_nbytes-1:0][7:0]    w_padded;
    logic [c_nbytes-1:0][7:0]    r_snap;
    logic [c_cnt_w-1:0]          r_cnt;
    logic [7:0]                  r_chk;
    logic [7:0]                  r_tx_byte;
    logic [c_idx_w-1:0]          w_idx;
    logic [7:0]                  w_next_byte;
    logic                        w_cur_is_data;

    assign w_padded  = c_pad_w'(i_data_from_pipe);
    assign o_tx_byte = r_tx_byte;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        os_tx_start  = 1'b0;
        o_busy       = 1'b1;
        os_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (is_start) begin
                    w_next_state = S_SEND;
                end
            end
            S_SEND: begin
                os_tx_start  = 1'b1;
                w_next_state = S_WAIT;
            end
            S_WAIT: begin
                if (i_tx_done) begin
                    w_next_state = (r_cnt == c_last_item) ? S_DONE : S_SEND;
                end
            end
            S_DONE: begin
                os_done      = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // The byte after item r_cnt: data byte r_cnt (in send order), or CHK once
    // the last data byte (still held in r_tx_byte) has been folded in.
    always_comb begin
        w_idx         = MSB_FIRST ? (c_idx_w'(c_nbytes - 1) - c_idx_w'(r_cnt))
                                  : c_idx_w'(r_cnt);
        w_cur_is_data = (r_cnt != '0) && (r_cnt != c_last_item);
        w_next_byte   = (r_cnt == c_last_data) ? (r_chk ^ r_tx_byte) : r_snap[w_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_snap    <= '0;
            r_cnt     <= '0;
            r_chk     <= 8'h00;
            r_tx_byte <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (is_start) begin
                        r_snap    <= w_padded;
                        r_cnt     <= '0;
                        r_chk     <= 8'h00;
                        r_tx_byte <= HEADER;
                    end
                end
                S_WAIT: begin
                    if (i_tx_done) begin
                        if (w_cur_is_data) begin
                            r_chk <= r_chk ^ r_tx_byte;
                        end
                        if (r_cnt != c_last_item) begin
                            r_cnt     <= r_cnt + c_cnt_w'(1);
                            r_tx_byte <= w_next_byte;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_debug_dump_serializer.sv
`default_nettype none
// Scoreboard bench: two DUTs (LSB-first and MSB-first) share stimulus; a
// reference model pushes expected bytes, a monitor pops them on each start pulse.
module tb_debug_dump_serializer;

    localparam int         DW  = 20;
    localparam int         NB  = (DW + 7) / 8;
    localparam logic [7:0] HDR = 8'hA5;

    logic          clk;
    logic          rst;
    logic          is_start;
    logic          tx_done;
    logic [DW-1:0] data;
    logic [7:0]    tx_byte [2];
    logic          start   [2];
    logic          busy    [2];
    logic          done    [2];

    debug_dump_serializer #(.DATA_W(DW), .HEADER(HDR), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .i_data_from_pipe(data), .is_start(is_start),
        .i_tx_done(tx_done), .o_tx_byte(tx_byte[0]), .os_tx_start(start[0]),
        .o_busy(busy[0]), .os_done(done[0])
    );

    debug_dump_serializer #(.DATA_W(DW), .HEADER(HDR), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .i_data_from_pipe(data), .is_start(is_start),
        .i_tx_done(tx_done), .o_tx_byte(tx_byte[1]), .os_tx_start(start[1]),
        .o_busy(busy[1]), .os_done(done[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         tests  = 0;
    int         failed = 0;
    int         cyc    = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    bit         pend       [2];
    bit         idle_next  [2];
    int         last_start [2];
    logic [7:0] last_byte  [2];
    int         nstart     [2];

    // Reference model: byte k of the zero-extended bus, XOR of data bytes.
    task automatic push_frame(input logic [DW-1:0] d);
        int unsigned v;
        logic [7:0]  b [NB];
        logic [7:0]  chk;
        v   = 32'(d);
        chk = 8'h00;
        for (int k = 0; k < NB; k++) begin
            b[k] = 8'((v >> (8 * k)) & 32'hFF);
            chk  = chk ^ b[k];
        end
        q0.push_back(HDR);
        q1.push_back(HDR);
        for (int k = 0; k < NB; k++) q0.push_back(b[k]);
        for (int k = NB - 1; k >= 0; k--) q1.push_back(b[k]);
        q0.push_back(chk);
        q1.push_back(chk);
        pend[0] = 1'b1;
        pend[1] = 1'b1;
    endtask

    // Monitor
    initial begin
        logic [7:0] e;
        for (int d = 0; d < 2; d++) begin
            pend[d] = 1'b0; idle_next[d] = 1'b0; last_start[d] = -1;
            last_byte[d] = 8'h00; nstart[d] = 0;
        end
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                for (int d = 0; d < 2; d++) begin
                    if (start[d]) begin
                        tests++;
                        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                            failed++;
                            $display("FAIL unexpected_start dut%0d byte=%h required=no start", d, tx_byte[d]);
                        end else begin
                            e = (d == 0) ? q0.pop_front() : q1.pop_front();
                            if (tx_byte[d] !== e) begin
                                failed++;
                                $display("FAIL tx_byte dut%0d actual=%h required=%h", d, tx_byte[d], e);
                            end
                        end
                        if (last_start[d] >= 0) begin
                            tests++;
                            if (cyc - last_start[d] < 2) begin
                                failed++;
                                $display("FAIL start_spacing dut%0d actual=%0d required>=2", d, cyc - last_start[d]);
                            end
                        end
                        last_start[d] = cyc;
                        last_byte[d]  = tx_byte[d];
                        nstart[d]++;
                    end else if (busy[d] && !done[d]) begin
                        tests++;
                        if (tx_byte[d] !== last_byte[d]) begin
                            failed++;
                            $display("FAIL byte_hold dut%0d actual=%h required=%h", d, tx_byte[d], last_byte[d]);
                        end
                    end
                    if (idle_next[d]) begin
                        idle_next[d] = 1'b0;
                        tests++;
                        if (busy[d] !== 1'b0) begin
                            failed++;
                            $display("FAIL busy_after_done dut%0d actual=%b required=0", d, busy[d]);
                        end
                    end
                    if (done[d]) begin
                        tests++;
                        if (!pend[d] || (d == 0 && q0.size() != 0) || (d == 1 && q1.size() != 0)) begin
                            failed++;
                            $display("FAIL done_early dut%0d pending=%0d left=%0d required=1/0", d, pend[d],
                                     (d == 0) ? q0.size() : q1.size());
                        end
                        pend[d]      = 1'b0;
                        idle_next[d] = 1'b1;
                    end
                end
            end
        end
    end

    // UART responder: real ack 1..4 cycles after each start, plus ignored
    // spurious acks during SEND, DONE and IDLE.
    initial begin
        int countdown;
        tx_done   = 1'b0;
        countdown = 0;
        forever begin
            @(negedge clk);
            tx_done = 1'b0;
            if (rst) begin
                countdown = 0;
            end else begin
                if (countdown > 0) begin
                    countdown--;
                    if (countdown == 0) tx_done = 1'b1;
                end
                if (start[0]) begin
                    countdown = $urandom_range(1, 4);
                    if ($urandom_range(0, 1) == 1) tx_done = 1'b1;
                end else if (done[0] || !busy[0]) begin
                    if ($urandom_range(0, 3) == 0) tx_done = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check_bit(input string name, input logic act, input logic req);
        tests++;
        if (act !== req) begin
            failed++;
            $display("FAIL %s actual=%b required=%b", name, act, req);
        end
    endtask

    task automatic check_reset_outputs();
        for (int d = 0; d < 2; d++) begin
            tests++;
            if (tx_byte[d] !== 8'h00 || start[d] !== 1'b0 || busy[d] !== 1'b0 || done[d] !== 1'b0) begin
                failed++;
                $display("FAIL reset_outputs dut%0d actual=%h/%b/%b/%b required=00/0/0/0",
                         d, tx_byte[d], start[d], busy[d], done[d]);
            end
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy[0] || busy[1]) && n < 100) begin tick(); n++; end
        tests++;
        if (busy[0] || busy[1]) begin
            failed++;
            $display("FAIL idle_timeout actual=busy required=idle");
        end
    endtask

    task automatic launch(input logic [DW-1:0] d);
        wait_idle();
        nstart[0] = 0;
        nstart[1] = 0;
        push_frame(d);
        data     = d;
        is_start = 1'b1;
        tick();
        is_start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check_bit("busy_after_start", busy[k], 1'b1);
            check_bit("start_after_start", start[k], 1'b1);
        end
    endtask

    task automatic finish_frame();
        int n = 0;
        while ((pend[0] || pend[1]) && n < 400) begin tick(); n++; end
        tests++;
        if (pend[0] || pend[1]) begin
            failed++;
            $display("FAIL frame_timeout actual=pending required=done");
            q0.delete(); q1.delete();
            pend[0] = 1'b0; pend[1] = 1'b0;
        end
    endtask

    task automatic run_frame(input logic [DW-1:0] d, input bit disturb);
        launch(d);
        if (disturb) begin
            tick();
            data     = DW'($urandom);
            is_start = 1'b1;
            tick();
            is_start = 1'b0;
        end
        finish_frame();
        repeat (3) tick();
        check_bit("no_second_frame", busy[0] | busy[1], 1'b0);
    endtask

    initial begin
        rst      = 1'b1;
        is_start = 1'b1;
        data     = 20'hABCDE;
        repeat (3) begin
            tick();
            check_reset_outputs();
        end
        rst      = 1'b0;
        is_start = 1'b0;
        tick();
        check_reset_outputs();

        run_frame(20'hABCDE, 1'b0);
        run_frame(20'hABCDE, 1'b1);
        for (int i = 0; i < 25; i++) begin
            run_frame(DW'($urandom), ($urandom_range(0, 2) == 0));
        end

        // Abort after two acknowledged bytes, then a fresh all-zero frame.
        launch(20'h5A5A5);
        begin
            int n = 0;
            while (nstart[0] < 3 && n < 100) begin tick(); n++; end
            tests++;
            if (nstart[0] < 3) begin
                failed++;
                $display("FAIL abort_wait_timeout actual=%0d required=3", nstart[0]);
            end
        end
        tick();
        rst = 1'b1;
        q0.delete(); q1.delete();
        for (int d = 0; d < 2; d++) begin
            pend[d] = 1'b0; idle_next[d] = 1'b0; last_start[d] = -1;
        end
        tick();
        check_reset_outputs();
        rst = 1'b0;
        repeat (5) tick();
        check_bit("idle_after_abort", busy[0] | busy[1], 1'b0);
        run_frame(20'h00000, 1'b0);
        run_frame(DW'($urandom), 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
